// File: rtl/fpu_wb_queue.sv
// FPU writeback queue: buffers FPU data/compare results in arrival order and
// presents the oldest entry on the writeback bus. It also throttles issue with an in-flight credit count.
module fpu_wb_queue #(
  parameter int LG_PRF_WIDTH = 4,
  parameter int LG_ROB_WIDTH = 4,
  parameter int LG_FCR_WIDTH = 4,
  parameter int LG_DEPTH     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fpu_start,
  input  logic                    fpu_val,
  input  logic                    fpu_cmp_val,
  input  logic [63:0]             fpu_y,
  input  logic [LG_ROB_WIDTH-1:0] fpu_rob_ptr,
  input  logic [LG_PRF_WIDTH-1:0] fpu_dst_ptr,
  input  logic [LG_FCR_WIDTH-1:0] fpu_fcr_ptr,
  output logic                    issue_ok,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic                    wb_is_fcr,
  output logic [63:0]             wb_data,
  output logic [LG_ROB_WIDTH-1:0] wb_rob_ptr,
  output logic [LG_PRF_WIDTH-1:0] wb_dst_ptr,
  output logic [LG_FCR_WIDTH-1:0] wb_fcr_ptr,
  output logic [LG_DEPTH:0]       occupancy,
  output logic                    overflow
);

  localparam int unsigned DEPTH = 1 << LG_DEPTH;
  localparam logic [LG_DEPTH:0]   FULL_OCC = (LG_DEPTH+1)'(DEPTH);
  localparam logic [LG_DEPTH+2:0] CREDITS  = (LG_DEPTH+3)'(DEPTH);

  logic [63:0]             mem_y      [DEPTH];
  logic [LG_ROB_WIDTH-1:0] mem_rob    [DEPTH];
  logic [LG_PRF_WIDTH-1:0] mem_dst    [DEPTH];
  logic [LG_FCR_WIDTH-1:0] mem_fcr    [DEPTH];
  logic                    mem_is_fcr [DEPTH];

  logic [LG_DEPTH-1:0] head, tail;
  logic [LG_DEPTH:0]   occ;
  logic [LG_DEPTH+1:0] inflight;
  logic                ovf;

  logic enq, deq, full, do_enq;

  always_comb begin
    enq    = fpu_val | fpu_cmp_val;
    full   = (occ == FULL_OCC);
    deq    = (occ != '0) & wb_ready;
    // A full queue still accepts when the head leaves on the same edge.
    do_enq = enq & (~full | deq);
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem_y[tail]      <= fpu_y;
      mem_rob[tail]    <= fpu_rob_ptr;
      mem_dst[tail]    <= fpu_dst_ptr;
      mem_fcr[tail]    <= fpu_fcr_ptr;
      mem_is_fcr[tail] <= fpu_cmp_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      inflight <= '0;
      ovf      <= 1'b0;
    end else begin
      if (do_enq) tail <= tail + 1'b1;
      if (deq)    head <= head + 1'b1;
      case ({do_enq, deq})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (fpu_start & ~enq)
        inflight <= inflight + 1'b1;
      else if (~fpu_start & enq & (inflight != '0))
        inflight <= inflight - 1'b1;
      if (enq & ~do_enq) ovf <= 1'b1;
    end
  end

  always_comb begin
    wb_valid   = (occ != '0);
    wb_data    = mem_y[head];
    wb_rob_ptr = mem_rob[head];
    wb_dst_ptr = mem_dst[head];
    wb_fcr_ptr = mem_fcr[head];
    wb_is_fcr  = mem_is_fcr[head];
    occupancy  = occ;
    overflow   = ovf;
    issue_ok   = ({2'b00, occ} + {1'b0, inflight}) < CREDITS;
  end

endmodule

// File: tb/tb_fpu_wb_queue.sv
// Directed bench for fpu_wb_queue: a vector table stepped one clock per row,
// then a hand-written compare-result hold and mixed-type ordering sequence.
module tb_fpu_wb_queue;

  logic        clk = 1'b0;
  logic        reset, fpu_start, fpu_val, fpu_cmp_val, wb_ready;
  logic [63:0] fpu_y;
  logic [3:0]  fpu_rob_ptr, fpu_dst_ptr, fpu_fcr_ptr;
  logic        issue_ok, wb_valid, wb_is_fcr, overflow;
  logic [63:0] wb_data;
  logic [3:0]  wb_rob_ptr, wb_dst_ptr, wb_fcr_ptr;
  logic [2:0]  occupancy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fpu_wb_queue #(.LG_PRF_WIDTH(4), .LG_ROB_WIDTH(4), .LG_FCR_WIDTH(4), .LG_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .fpu_start(fpu_start), .fpu_val(fpu_val),
    .fpu_cmp_val(fpu_cmp_val), .fpu_y(fpu_y), .fpu_rob_ptr(fpu_rob_ptr),
    .fpu_dst_ptr(fpu_dst_ptr), .fpu_fcr_ptr(fpu_fcr_ptr), .issue_ok(issue_ok),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_is_fcr(wb_is_fcr),
    .wb_data(wb_data), .wb_rob_ptr(wb_rob_ptr), .wb_dst_ptr(wb_dst_ptr),
    .wb_fcr_ptr(wb_fcr_ptr), .occupancy(occupancy), .overflow(overflow)
  );

  typedef struct {
    logic        rst, st, v, c, rdy;
    logic [63:0] y;
    logic [3:0]  rob, dst;
    logic [2:0]  e_occ;
    logic        e_val, e_iok, e_ovf, chk;
    logic [63:0] e_y;
    logic [3:0]  e_rob, e_dst;
    logic        e_isf;
  } vec_t;

  vec_t vecs[34];

  function automatic vec_t mk(input logic rst, st, v, c, rdy, input logic [63:0] y,
                              input logic [3:0] rob, dst, input logic [2:0] e_occ,
                              input logic e_val, e_iok, e_ovf, chk, input logic [63:0] e_y,
                              input logic [3:0] e_rob, e_dst, input logic e_isf);
    vec_t r;
    r.rst = rst; r.st = st; r.v = v; r.c = c; r.rdy = rdy; r.y = y; r.rob = rob; r.dst = dst;
    r.e_occ = e_occ; r.e_val = e_val; r.e_iok = e_iok; r.e_ovf = e_ovf; r.chk = chk;
    r.e_y = e_y; r.e_rob = e_rob; r.e_dst = e_dst; r.e_isf = e_isf;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, st, v, c, rdy, input logic [63:0] y,
                      input logic [3:0] rob, dst, fcr);
    reset = rst; fpu_start = st; fpu_val = v; fpu_cmp_val = c; wb_ready = rdy;
    fpu_y = y; fpu_rob_ptr = rob; fpu_dst_ptr = dst; fpu_fcr_ptr = fcr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [2:0] e_occ,
                             input logic e_val, e_iok, e_ovf);
    check({tag, ".occupancy"}, 64'(occupancy), 64'(e_occ));
    check({tag, ".wb_valid"},  64'(wb_valid),  64'(e_val));
    check({tag, ".issue_ok"},  64'(issue_ok),  64'(e_iok));
    check({tag, ".overflow"},  64'(overflow),  64'(e_ovf));
  endtask

  initial begin
    //                rst st v c rdy  y                     rob  dst  occ val iok ovf chk e_y                   erob edst isf
    vecs[0]  = mk(1, 0, 0, 0, 0, 64'h0,                 0, 0, 0, 0, 1, 0, 0, 64'h0,                 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 1, 64'h0,                 0, 0, 0, 0, 1, 0, 0, 64'h0,                 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 1, 64'h0,                 0, 0, 0, 0, 1, 0, 0, 64'h0,                 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 0, 1, 64'h3FF0000000000000, 3, 5, 1, 1, 1, 0, 1, 64'h3FF0000000000000, 3, 5, 0);
    vecs[4]  = mk(0, 0, 0, 0, 1, 64'h0,                 0, 0, 0, 0, 1, 0, 0, 64'h0,                 0, 0, 0);
    // fill: four issues exhaust the credits, results back up with wb_ready low
    vecs[5]  = mk(0, 1, 0, 0, 0, 64'h0, 0, 0, 0, 0, 1, 0, 0, 64'h0, 0, 0, 0);
    vecs[6]  = mk(0, 1, 0, 0, 0, 64'h0, 0, 0, 0, 0, 1, 0, 0, 64'h0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 0, 0, 64'h0, 0, 0, 0, 0, 1, 0, 0, 64'h0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 0, 64'h1, 1, 1, 1, 1, 0, 0, 1, 64'h1, 1, 1, 0);
    vecs[10] = mk(0, 0, 1, 0, 0, 64'h2, 2, 2, 2, 1, 0, 0, 1, 64'h1, 1, 1, 0);
    vecs[11] = mk(0, 0, 1, 0, 0, 64'h3, 3, 3, 3, 1, 0, 0, 1, 64'h1, 1, 1, 0);
    vecs[12] = mk(0, 0, 1, 0, 0, 64'h4, 4, 4, 4, 1, 0, 0, 1, 64'h1, 1, 1, 0);
    // full with simultaneous enqueue and dequeue, then drain in order
    vecs[13] = mk(0, 0, 1, 0, 1, 64'h5, 5, 5, 4, 1, 0, 0, 1, 64'h2, 2, 2, 0);
    vecs[14] = mk(0, 0, 0, 0, 1, 64'h0, 0, 0, 3, 1, 1, 0, 1, 64'h3, 3, 3, 0);
    vecs[15] = mk(0, 0, 0, 0, 1, 64'h0, 0, 0, 2, 1, 1, 0, 1, 64'h4, 4, 4, 0);
    vecs[16] = mk(0, 0, 0, 0, 1, 64'h0, 0, 0, 1, 1, 1, 0, 1, 64'h5, 5, 5, 0);
    vecs[17] = mk(0, 0, 0, 0, 1, 64'h0, 0, 0, 0, 0, 1, 0, 0, 64'h0, 0, 0, 0);
    // results with no credits outstanding: inflight must stay at 0
    vecs[18] = mk(0, 0, 1, 0, 0, 64'h16, 6, 6, 1, 1, 1, 0, 1, 64'h16, 6, 6, 0);
    vecs[19] = mk(0, 0, 1, 0, 0, 64'h17, 7, 7, 2, 1, 1, 0, 1, 64'h16, 6, 6, 0);
    vecs[20] = mk(0, 0, 1, 0, 0, 64'h18, 8, 8, 3, 1, 1, 0, 1, 64'h16, 6, 6, 0);
    vecs[21] = mk(0, 0, 1, 0, 0, 64'h19, 9, 9, 4, 1, 0, 0, 1, 64'h16, 6, 6, 0);
    vecs[22] = mk(0, 0, 1, 0, 0, 64'hDEAD, 15, 15, 4, 1, 0, 1, 1, 64'h16, 6, 6, 0);
    vecs[23] = mk(0, 0, 0, 0, 0, 64'h0,  0, 0, 4, 1, 0, 1, 1, 64'h16, 6, 6, 0);
    vecs[24] = mk(0, 0, 0, 0, 1, 64'h0,  0, 0, 3, 1, 1, 1, 1, 64'h17, 7, 7, 0);
    vecs[25] = mk(0, 0, 0, 0, 1, 64'h0,  0, 0, 2, 1, 1, 1, 1, 64'h18, 8, 8, 0);
    vecs[26] = mk(0, 1, 0, 0, 1, 64'h0,  0, 0, 1, 1, 1, 1, 1, 64'h19, 9, 9, 0);
    // build occupancy 3 / inflight 1, then reset with conflicting activity
    vecs[27] = mk(0, 1, 1, 0, 0, 64'h20, 0, 0, 2, 1, 1, 1, 1, 64'h19, 9, 9, 0);
    vecs[28] = mk(0, 1, 0, 1, 0, 64'h21, 1, 1, 3, 1, 0, 1, 1, 64'h19, 9, 9, 0);
    vecs[29] = mk(1, 1, 1, 0, 1, 64'h22, 2, 2, 0, 0, 1, 0, 0, 64'h0,  0, 0, 0);
    vecs[30] = mk(0, 1, 0, 0, 0, 64'h0,  0, 0, 0, 0, 1, 0, 0, 64'h0,  0, 0, 0);
    vecs[31] = mk(0, 1, 0, 0, 0, 64'h0,  0, 0, 0, 0, 1, 0, 0, 64'h0,  0, 0, 0);
    vecs[32] = mk(0, 1, 0, 0, 0, 64'h0,  0, 0, 0, 0, 1, 0, 0, 64'h0,  0, 0, 0);
    vecs[33] = mk(0, 1, 0, 0, 0, 64'h0,  0, 0, 0, 0, 0, 0, 0, 64'h0,  0, 0, 0);

    for (int i = 0; i < 34; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vecs[i].rst, vecs[i].st, vecs[i].v, vecs[i].c, vecs[i].rdy,
           vecs[i].y, vecs[i].rob, vecs[i].dst, vecs[i].dst);
      check_state(tag, vecs[i].e_occ, vecs[i].e_val, vecs[i].e_iok, vecs[i].e_ovf);
      if (vecs[i].chk) begin
        check({tag, ".wb_data"},    wb_data,              vecs[i].e_y);
        check({tag, ".wb_rob_ptr"}, 64'(wb_rob_ptr),      64'(vecs[i].e_rob));
        check({tag, ".wb_dst_ptr"}, 64'(wb_dst_ptr),      64'(vecs[i].e_dst));
        check({tag, ".wb_is_fcr"},  64'(wb_is_fcr),       64'(vecs[i].e_isf));
      end
    end

    // compare result held stable while writeback stalls
    step(1, 0, 0, 0, 0, 64'h0, 0, 0, 0);
    check_state("cmp.reset", 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 64'h05, 7, 9, 2);
    for (int k = 0; k < 4; k++) begin
      string tag;
      tag = $sformatf("cmp.hold%0d", k);
      check_state(tag, 1, 1, 1, 0);
      check({tag, ".wb_is_fcr"},  64'(wb_is_fcr),  64'd1);
      check({tag, ".wb_data"},    wb_data,         64'h05);
      check({tag, ".wb_fcr_ptr"}, 64'(wb_fcr_ptr), 64'd2);
      check({tag, ".wb_rob_ptr"}, 64'(wb_rob_ptr), 64'd7);
      if (k < 3) step(0, 0, 0, 0, 0, 64'h0, 0, 0, 0);
    end

    // both valids -> one FCR entry; then a PRF entry behind it
    step(0, 0, 1, 1, 0, 64'h77, 1, 2, 3);
    check_state("both", 2, 1, 1, 0);
    step(0, 0, 1, 0, 0, 64'h88, 5, 4, 6);
    check_state("prf", 3, 1, 1, 0);
    step(0, 0, 0, 0, 1, 64'h0, 0, 0, 0);
    check_state("drain1", 2, 1, 1, 0);
    check("drain1.wb_data",    wb_data,         64'h77);
    check("drain1.wb_is_fcr",  64'(wb_is_fcr),  64'd1);
    check("drain1.wb_fcr_ptr", 64'(wb_fcr_ptr), 64'd3);
    step(0, 0, 0, 0, 1, 64'h0, 0, 0, 0);
    check_state("drain2", 1, 1, 1, 0);
    check("drain2.wb_data",    wb_data,         64'h88);
    check("drain2.wb_is_fcr",  64'(wb_is_fcr),  64'd0);
    check("drain2.wb_dst_ptr", 64'(wb_dst_ptr), 64'd4);
    step(0, 0, 0, 0, 1, 64'h0, 0, 0, 0);
    check_state("drain3", 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fpu_wb_queue.md
FPU_WB_QUEUE -- requirements
Module: fpu_wb_queue

Interface
REQ-001 Parameter LG_PRF_WIDTH, default 4, physical register pointer width.
REQ-002 Parameter LG_ROB_WIDTH, default 4, ROB pointer width.
REQ-003 Parameter LG_FCR_WIDTH, default 4, FCR rename pointer width.
REQ-004 Parameter LG_DEPTH, default 2, log2 of queue depth (DEPTH = 4).
REQ-005 clk  input  1  clock; all state updates on posedge clk.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 fpu_start  input  1  FPU op issued this cycle; counts as in-flight.
REQ-008 fpu_val  input  1  FPU data result valid this cycle.
REQ-009 fpu_cmp_val  input  1  FPU compare/FCR result valid this cycle.
REQ-010 fpu_y  input  64  FPU result data.
REQ-011 fpu_rob_ptr  input  LG_ROB_WIDTH  ROB tag of result.
REQ-012 fpu_dst_ptr  input  LG_PRF_WIDTH  destination PRF pointer.
REQ-013 fpu_fcr_ptr  input  LG_FCR_WIDTH  destination FCR pointer.
REQ-014 issue_ok  output  1  upstream may assert fpu_start this cycle.
REQ-015 wb_valid  output  1  head entry presented on writeback bus.
REQ-016 wb_ready  input  1  writeback bus accepts head this cycle.
REQ-017 wb_is_fcr  output  1  head targets FCR file (1) or PRF (0).
REQ-018 wb_data  output  64  head data.
REQ-019 wb_rob_ptr / wb_dst_ptr / wb_fcr_ptr  output  LG_ROB_WIDTH / LG_PRF_WIDTH / LG_FCR_WIDTH  head tags.
REQ-020 occupancy  output  LG_DEPTH+1  entries held, 0..DEPTH.
REQ-021 overflow  output  1  sticky error: enqueue dropped while full.

Function
REQ-022 Enqueue event = fpu_val | fpu_cmp_val; entry stores fpu_y, all three tags, is_fcr = fpu_cmp_val.
REQ-023 Storage is a circular FIFO of DEPTH entries; head/tail pointers wrap modulo DEPTH.
REQ-024 Dequeue event = wb_valid & wb_ready; head advances on the same clock edge.
REQ-025 wb_valid = (occupancy != 0); wb_* fields driven from head entry; no combinational path from fpu_* to wb_*.
REQ-026 Latency: enqueue into empty queue at edge N gives wb_valid=1 after edge N, i.e. 1 cycle.
REQ-027 Once wb_valid=1, wb_valid and all wb_* fields stay stable until dequeue (no retraction).
REQ-028 Simultaneous enqueue and dequeue: occupancy unchanged, ordering preserved; legal when full.
REQ-029 Enqueue while full without dequeue: entry dropped, state unchanged, overflow set to 1 until reset.
REQ-030 inflight counter (LG_DEPTH+2 bits): +1 on fpu_start, -1 on enqueue event, unchanged when both.
REQ-031 issue_ok = (occupancy + inflight) < DEPTH, combinational from registered state only.
REQ-032 Enqueue with inflight = 0 does not underflow the counter; inflight saturates at 0.
REQ-033 fpu_val and fpu_cmp_val both high: single entry, is_fcr = 1.
REQ-034 Results leave in arrival order; no reordering by type.

Reset
REQ-035 On reset: occupancy=0, head=tail=0, inflight=0, overflow=0, wb_valid=0, issue_ok=1.
REQ-036 Reset overrides any same-cycle enqueue, dequeue, or fpu_start; entries in flight are discarded.
REQ-037 Storage contents need not be reset; wb_data/tags are don't-care while wb_valid=0.

Verification
REQ-038 Single op: fpu_start, 2 cycles later fpu_val with y=0x3FF0000000000000, dst=5, rob=3, wb_ready=1 -> wb_valid one cycle later with those values, wb_is_fcr=0, occupancy returns to 0.
REQ-039 Fill: wb_ready=0, 4 fpu_start back-to-back -> issue_ok=0 after 4th; 4 results queued, occupancy=4; wb_ready=1 -> drained in order over 4 cycles, issue_ok=1.
REQ-040 Full plus simultaneous: occupancy=4, enqueue and wb_ready=1 same cycle -> occupancy stays 4, overflow=0, new entry emerges last.
REQ-041 Overflow: occupancy=4, wb_ready=0, forced fpu_val -> entry dropped, overflow=1, stays 1 until reset.
REQ-042 Compare result: fpu_cmp_val with y=0x05, fcr_ptr=2 -> wb_is_fcr=1, wb_data=0x05, wb_fcr_ptr=2; held stable across 3 cycles of wb_ready=0.
REQ-043 Reset mid-operation: occupancy=3, inflight=1, reset for 1 cycle -> next cycle occupancy=0, wb_valid=0, issue_ok=1, overflow=0.
